// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: row-scan sequencer for an LED matrix.
// Double-buffered frame store (writer fills the back plane, swap at frame
// boundaries), prescaler-timed row dwell, one-hot row select.
// Optional feature macro: MATRIX_SCAN_BLANK_EN adds BLANK_CYCLES of dead time
// at the start of every row period. When it is undefined, rows are driven
// back-to-back for the full DIV_LIMIT cycles.
module matrix_scan_controller #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int DIV_LIMIT    = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    input_clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic [ROWS-1:0]         row_sel,
    output logic [COLS-1:0]         col_drive,
    output logic                    frame_done
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int PRE_W = 26;

    localparam logic [PRE_W-1:0] DIV_LAST = PRE_W'(DIV_LIMIT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
`ifdef MATRIX_SCAN_BLANK_EN
    localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam logic [1:0] S_BLANK = 2'd1;
`endif
    localparam logic [1:0] S_DRIVE = 2'd2;

    // Reject parameter sets the scan timing cannot honour.
    if (ROWS < 2 || ROWS > 16 || COLS < 1 || COLS > 32 ||
        BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV_LIMIT ||
        DIV_LIMIT >= (1 << PRE_W)) begin : g_bad_params
        $error("matrix_scan_controller: illegal parameter combination");
    end

    logic [1:0]       r_state;
    logic [ROW_W-1:0] r_row;
    logic [PRE_W-1:0] r_presc;
    logic             r_swap_pend;
    logic             r_front_sel;   // 0: buffer A is front, 1: buffer B is front
    logic [COLS-1:0]  r_buf_a [ROWS];
    logic [COLS-1:0]  r_buf_b [ROWS];
    logic [ROWS-1:0]  r_row_sel;
    logic [COLS-1:0]  r_col_drive;
    logic             r_swap_ack;
    logic             r_frame_done;

    logic [1:0]       w_state_nx;
    logic [ROW_W-1:0] w_row_nx;
    logic [PRE_W-1:0] w_presc_nx;
    logic             w_wrap;
    logic             w_swap_now;
    logic             w_pend_nx;
    logic             w_front_nx;
    logic             w_drive_nx;
    logic [31:0]      w_wr_row_ext;
    logic             w_wr_ok;
    logic [ROWS-1:0]  w_row_onehot;
    logic [COLS-1:0]  w_front_row;

    assign w_wr_row_ext = 32'(wr_row);
    assign w_wr_ok      = (w_wr_row_ext < 32'(ROWS));

    // Scan sequencer next state: idle / blank / drive with prescaler and row index.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_presc_nx = r_presc;
        w_wrap     = 1'b0;
        if (!enable) begin
            w_state_nx = S_IDLE;
            w_row_nx   = '0;
            w_presc_nx = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_row_nx   = '0;
                    w_presc_nx = '0;
`ifdef MATRIX_SCAN_BLANK_EN
                    w_state_nx = S_BLANK;
`else
                    w_state_nx = S_DRIVE;
`endif
                end
`ifdef MATRIX_SCAN_BLANK_EN
                S_BLANK: begin
                    // Prescaler keeps counting into DRIVE so the row period stays DIV_LIMIT.
                    w_presc_nx = r_presc + 1'b1;
                    if (r_presc == BLANK_LAST) begin
                        w_state_nx = S_DRIVE;
                    end
                end
`endif
                S_DRIVE: begin
                    if (r_presc == DIV_LAST) begin
                        w_presc_nx = '0;
                        w_wrap     = (r_row == ROW_LAST);
                        w_row_nx   = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
`ifdef MATRIX_SCAN_BLANK_EN
                        w_state_nx = S_BLANK;
`endif
                    end else begin
                        w_presc_nx = r_presc + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_row_nx   = '0;
                    w_presc_nx = '0;
                end
            endcase
        end
    end

    // Swap bookkeeping: execute at a frame wrap, or immediately while idle.
    always_comb begin
        w_swap_now = (r_swap_pend || swap_req) && (w_wrap || (r_state == S_IDLE));
        w_pend_nx  = w_swap_now ? 1'b0 : (r_swap_pend || swap_req);
        w_front_nx = r_front_sel ^ w_swap_now;
    end

    // Next-cycle output pattern, read from the front plane as it will be after this edge.
    always_comb begin
        w_drive_nx   = (w_state_nx == S_DRIVE);
        w_row_onehot = ROWS'(1) << w_row_nx;
        w_front_row  = w_front_nx ? r_buf_b[w_row_nx] : r_buf_a[w_row_nx];
        // A write landing in the same edge as a swap goes to the plane that
        // becomes front; forward it so the first driven cycle is not stale.
        if (wr_en && w_wr_ok && w_swap_now && (wr_row == w_row_nx)) begin
            w_front_row = wr_data;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge input_clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_presc      <= '0;
            r_swap_pend  <= 1'b0;
            r_front_sel  <= 1'b0;
            r_row_sel    <= '0;
            r_col_drive  <= '0;
            r_swap_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state      <= w_state_nx;
            r_row        <= w_row_nx;
            r_presc      <= w_presc_nx;
            r_swap_pend  <= w_pend_nx;
            r_front_sel  <= w_front_nx;
            r_swap_ack   <= w_swap_now;
            r_frame_done <= w_wrap;
            r_row_sel    <= w_drive_nx ? w_row_onehot : '0;
            r_col_drive  <= w_drive_nx ? w_front_row : '0;
        end
    end

    // Frame store: writes always target the plane that is back before this edge.
    always_ff @(posedge input_clock) begin
        if (!reset_n) begin
            // NOTE: the frame store is cleared on reset so a fresh display starts dark; this keeps it in flops, not RAM.
            for (int i = 0; i < ROWS; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
            end
        end else if (wr_en && w_wr_ok) begin
            if (r_front_sel) begin
                r_buf_a[wr_row] <= wr_data;
            end else begin
                r_buf_b[wr_row] <= wr_data;
            end
        end
    end

    assign swap_ack   = r_swap_ack;
    assign row_sel    = r_row_sel;
    assign col_drive  = r_col_drive;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: scoreboard bench for matrix_scan_controller
// (ROWS=4, COLS=8, DIV_LIMIT=10, BLANK_CYCLES=2). Expected drive runs, frame
// pulses and swap acks are queued as stimulus is issued, keyed by the clock
// edge they follow; a monitor pops and compares. Follows MATRIX_SCAN_BLANK_EN.
module tb_matrix_scan_controller;

    localparam int DIV = 10;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    localparam int LEN = DIV - BLK;

    typedef struct {
        int         start;
        logic [3:0] sel;
        logic [7:0] col;
        int         len;
    } run_t;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic [3:0] row_sel;
    logic [7:0] col_drive;
    logic       frame_done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    run_t q_run[$];
    int   q_fd[$];
    int   q_ack[$];

    matrix_scan_controller #(
        .ROWS(4), .COLS(8), .DIV_LIMIT(DIV), .BLANK_CYCLES(2)
    ) dut (
        .input_clock(clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .row_sel    (row_sel),
        .col_drive  (col_drive),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the index of the most recent posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at edge %0d: event with no expectation queued", name, cyc);
    endtask

    // Return at the negedge just before posedge e, so inputs set now are sampled at e.
    task automatic drive_at(input int e);
        do @(negedge clk); while (cyc < e - 1);
    endtask

    task automatic push_run(input int start, input logic [3:0] sel, input logic [7:0] col, input int len);
        run_t r;
        r.start = start;
        r.sel   = sel;
        r.col   = col;
        r.len   = len;
        q_run.push_back(r);
    endtask

    // Full frame starting at row-period edge k; cols packed {row3,row2,row1,row0}.
    task automatic push_frame(input int k, input logic [31:0] cols);
        for (int r = 0; r < 4; r++) begin
            push_run(k + r * DIV + BLK, 4'(1 << r), cols[8*r +: 8], LEN);
        end
    endtask

    task automatic write_row(input logic [1:0] row, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_row  = row;
        wr_data = data;
    endtask

    // Monitor: splits row_sel into drive runs and matches pulses to queued edges.
    logic [3:0] prev_sel = '0;
    int         run_start;
    logic [3:0] run_sel;
    logic [7:0] run_col;
    logic       run_stable;

    always @(negedge clk) begin
        if (row_sel !== prev_sel) begin
            if (prev_sel != '0) begin
                if (q_run.size() == 0) begin
                    unexpected("drive_run");
                end else begin
                    run_t x;
                    x = q_run.pop_front();
                    check("run_start", 64'(run_start), 64'(x.start));
                    check("run_row_sel", 64'(run_sel), 64'(x.sel));
                    check("run_col_drive", 64'(run_col), 64'(x.col));
                    check("run_length", 64'(cyc - run_start), 64'(x.len));
                    check("run_col_stable", 64'(run_stable), 64'(1));
                end
            end
            if (row_sel != '0) begin
                run_start  = cyc;
                run_sel    = row_sel;
                run_col    = col_drive;
                run_stable = 1'b1;
            end
        end else if (row_sel != '0 && col_drive !== run_col) begin
            run_stable = 1'b0;
        end
        if (row_sel == '0) check("col_zero_when_blank", 64'(col_drive), 64'(0));
        else               check("row_sel_onehot", 64'($onehot(row_sel)), 64'(1));
        if (swap_ack === 1'b1) begin
            if (q_ack.size() == 0) unexpected("swap_ack");
            else check("swap_ack_edge", 64'(cyc), 64'(q_ack.pop_front()));
        end
        if (frame_done === 1'b1) begin
            if (q_fd.size() == 0) unexpected("frame_done");
            else check("frame_done_edge", 64'(cyc), 64'(q_fd.pop_front()));
        end
        prev_sel = row_sel;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, k2, d, k3;
        reset_n  = 1'b0;
        enable   = 1'b1;
        wr_en    = 1'b0;
        wr_row   = '0;
        wr_data  = '0;
        swap_req = 1'b0;

        // Reset held for edges 1..3 with enable high; first live edge is 4.
        push_run(4 + BLK, 4'b0001, 8'h00, 3);
        drive_at(4);
        check("reset_row_sel", 64'(row_sel), 64'(0));
        check("reset_col_drive", 64'(col_drive), 64'(0));
        check("reset_swap_ack", 64'(swap_ack), 64'(0));
        check("reset_frame_done", 64'(frame_done), 64'(0));
        reset_n = 1'b1;
        drive_at(4 + BLK + 3);
        enable = 1'b0;
        e = 4 + BLK + 3;

        // Load back rows while idle, swap (acked next edge), then scan.
        drive_at(e + 1); write_row(2'd0, 8'h81);
        drive_at(e + 2); write_row(2'd1, 8'h42);
        drive_at(e + 3); write_row(2'd2, 8'h24);
        drive_at(e + 4); write_row(2'd3, 8'h18);
        drive_at(e + 5); wr_en = 1'b0; swap_req = 1'b1;
        q_ack.push_back(e + 5);
        k2 = e + 6;
        for (int f = 0; f < 4; f++) begin
            push_frame(k2 + 40 * f, {8'h18, 8'h24, 8'h42, 8'h81});
            q_fd.push_back(k2 + 40 * (f + 1));
        end
        drive_at(k2); swap_req = 1'b0; enable = 1'b1;

        // Write back row 2 without a swap: frames 0..3 keep showing 8'h24.
        drive_at(k2 + 5); write_row(2'd2, 8'h00);
        drive_at(k2 + 6); wr_en = 1'b0;

        // Mid-frame (row 1 driving) write + swap request: acked at the next wrap.
        q_ack.push_back(k2 + 160);
        push_frame(k2 + 160, {8'h18, 8'h00, 8'h42, 8'hFF});
        q_fd.push_back(k2 + 200);
        drive_at(k2 + 132); write_row(2'd0, 8'hFF); swap_req = 1'b1;
        drive_at(k2 + 133); write_row(2'd1, 8'h42); swap_req = 1'b0;
        drive_at(k2 + 134); write_row(2'd3, 8'h18);
        drive_at(k2 + 135); wr_en = 1'b0;

        // Request in the wrap cycle itself, plus a write at that edge (pre-swap back).
        q_ack.push_back(k2 + 200);
        push_run(k2 + 200 + BLK, 4'b0001, 8'h99, LEN);
        push_run(k2 + 210 + BLK, 4'b0010, 8'h42, LEN);
        drive_at(k2 + 200); swap_req = 1'b1; write_row(2'd0, 8'h99);
        drive_at(k2 + 201); swap_req = 1'b0; wr_en = 1'b0;

        // Pending swap, then enable drop in row 2 after its 5th drive cycle.
        drive_at(k2 + 212); swap_req = 1'b1;
        drive_at(k2 + 213); swap_req = 1'b0; write_row(2'd0, 8'h3C);
        drive_at(k2 + 214); wr_en = 1'b0;
        push_run(k2 + 220 + BLK, 4'b0100, 8'h24, 5);
        d = k2 + 225 + BLK;
        q_ack.push_back(d + 1);
        drive_at(d); enable = 1'b0;

        // Re-enable: restart at row 0 showing the swapped-in plane.
        k3 = d + 3;
        push_frame(k3, {8'h18, 8'h00, 8'h42, 8'h3C});
        q_fd.push_back(k3 + 40);
        push_run(k3 + 40 + BLK, 4'b0001, 8'h3C, LEN);
        drive_at(k3); enable = 1'b1;
        drive_at(k3 + 50); enable = 1'b0;

        drive_at(k3 + 60);
        check("runs_outstanding", 64'(q_run.size()), 64'(0));
        check("frame_done_outstanding", 64'(q_fd.size()), 64'(0));
        check("swap_ack_outstanding", 64'(q_ack.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
